adat_frame_decoder: RTL and testbench

- Sits directly downstream of the ADAT receive ADPLL. Consumes the recovered bit clock and the raw ADAT stream, both handled in the refclk domain.
- Samples and NRZI-decodes the stream, finds ADAT frame sync and checks every separator bit.
- Deserialises each 256-bit frame into 4 user bits and 8 × 24-bit channel samples, and reports lock/error status to the ADAT input top level.

---
 rtl/adat_frame_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_adat_frame_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adat_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : adat_frame_decoder
// Description : ADAT frame decoder. Synchronises and NRZI-decodes the raw
//               stream on recovered bit-clock ticks, finds frame sync, checks
//               separators and emits 8 x 24-bit channel samples plus user
//               bits, with lock tracking and a bit-clock watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module adat_frame_decoder #(
    parameter int SYNC_ZEROS  = 10,
    parameter int LOCK_FRAMES = 2,
    parameter int WDOG_CYCLES = 64
) (
    input  logic        refclk,
    input  logic        reset,
    input  logic        sync_stream,
    input  logic        bclk,
    output logic [23:0] out_data,
    output logic [2:0]  out_chan,
    output logic        out_valid,
    output logic [3:0]  out_user,
    output logic        frame_done,
    output logic        locked,
    output logic        sync_err
);

    localparam logic [1:0] c_HUNT = 2'd0;
    localparam logic [1:0] c_USER = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    localparam int             c_GW          = $clog2(LOCK_FRAMES + 1);
    localparam int             c_WW          = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_GW-1:0] c_GOOD_MAX   = c_GW'(LOCK_FRAMES);
    localparam logic [c_WW-1:0] c_WDOG       = c_WW'(WDOG_CYCLES);
    localparam logic [4:0]      c_SYNC_ZEROS = 5'(SYNC_ZEROS);

    logic [2:0]      r_sync_sr;
    logic            r_bclk_d;
    logic            r_s_prev;
    logic            w_bit_tick;
    logic            w_bit;
    logic            w_err;
    logic            w_wd_fire;
    logic [1:0]      r_state;
    logic [4:0]      r_zero_cnt;
    logic [3:0]      r_user_sr;
    logic [2:0]      r_bit_pos;
    logic [2:0]      r_nib_sub;
    logic [2:0]      r_chan;
    logic [23:0]     r_sample_sr;
    logic            r_emit_pend;
    logic [2:0]      r_emit_chan;
    logic            r_done_pend;
    logic [c_GW-1:0] r_good_cnt;
    logic [c_WW-1:0] r_wd_cnt;
    logic            r_locked;
    logic            r_sync_err;
    logic            r_out_valid;
    logic [23:0]     r_out_data;
    logic [2:0]      r_out_chan;
    logic [3:0]      r_out_user;
    logic            r_frame_done;

    assign w_bit_tick = bclk & ~r_bclk_d;
    assign w_bit      = r_sync_sr[2] ^ r_s_prev;
    // The watchdog fires once on the cycle the count would reach its limit
    assign w_wd_fire  = !w_bit_tick && (r_wd_cnt == c_WDOG - 1'b1);

    // Stream synchroniser and bit-clock edge register
    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            r_sync_sr <= 3'd0;
            r_bclk_d  <= 1'b0;
        end else begin
            r_sync_sr <= {r_sync_sr[1:0], sync_stream};
            r_bclk_d  <= bclk;
        end
    end

    // Watchdog: counts refclk cycles since the last bit tick, saturating
    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt <= '0;
        end else if (w_bit_tick) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != c_WDOG) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Framing error detection on the current decoded bit
    always_comb begin
        w_err = 1'b0;
        if (w_bit_tick) begin
            case (r_state)
                c_HUNT:         w_err = w_bit && (r_zero_cnt < c_SYNC_ZEROS) && r_locked;
                c_USER, c_DATA: w_err = (r_bit_pos == 3'd4) && !w_bit;
                default:        w_err = 1'b0;
            endcase
        end
    end

    // Frame FSM, deserialiser and lock tracking
    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            r_s_prev    <= 1'b0;
            r_state     <= c_HUNT;
            r_zero_cnt  <= 5'd0;
            r_user_sr   <= 4'd0;
            r_bit_pos   <= 3'd0;
            r_nib_sub   <= 3'd0;
            r_chan      <= 3'd0;
            r_sample_sr <= 24'd0;
            r_emit_pend <= 1'b0;
            r_emit_chan <= 3'd0;
            r_done_pend <= 1'b0;
            r_good_cnt  <= '0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_sync_err  <= 1'b0;
            r_emit_pend <= 1'b0;
            r_done_pend <= 1'b0;
            if (w_bit_tick) begin
                r_s_prev <= r_sync_sr[2];
            end
            // Frame completion lands one cycle after the final separator
            if (r_done_pend) begin
                if (r_good_cnt != c_GOOD_MAX) begin
                    r_good_cnt <= r_good_cnt + 1'b1;
                end
                if (r_good_cnt >= c_GOOD_MAX - 1'b1) begin
                    r_locked <= 1'b1;
                end
            end
            if (w_wd_fire || w_err) begin
                // Any loss of framing discards the partial frame
                r_state    <= c_HUNT;
                r_zero_cnt <= 5'd0;
                r_good_cnt <= '0;
                r_locked   <= 1'b0;
                r_sync_err <= 1'b1;
            end else if (w_bit_tick) begin
                case (r_state)
                    c_HUNT: begin
                        if (!w_bit) begin
                            if (r_zero_cnt != 5'd31) begin
                                r_zero_cnt <= r_zero_cnt + 5'd1;
                            end
                        end else begin
                            r_zero_cnt <= 5'd0;
                            if (r_zero_cnt >= c_SYNC_ZEROS) begin
                                r_state   <= c_USER;
                                r_bit_pos <= 3'd0;
                            end
                        end
                    end
                    c_USER: begin
                        if (r_bit_pos != 3'd4) begin
                            r_user_sr <= {r_user_sr[2:0], w_bit};
                            r_bit_pos <= r_bit_pos + 3'd1;
                        end else begin
                            r_state   <= c_DATA;
                            r_bit_pos <= 3'd0;
                            r_nib_sub <= 3'd0;
                            r_chan    <= 3'd0;
                        end
                    end
                    c_DATA: begin
                        if (r_bit_pos != 3'd4) begin
                            r_sample_sr <= {r_sample_sr[22:0], w_bit};
                            r_bit_pos   <= r_bit_pos + 3'd1;
                        end else begin
                            r_bit_pos <= 3'd0;
                            if (r_nib_sub == 3'd5) begin
                                r_nib_sub   <= 3'd0;
                                r_emit_pend <= 1'b1;
                                r_emit_chan <= r_chan;
                                r_chan      <= r_chan + 3'd1;
                                if (r_chan == 3'd7) begin
                                    r_done_pend <= 1'b1;
                                    r_state     <= c_HUNT;
                                    r_zero_cnt  <= 5'd0;
                                end
                            end else begin
                                r_nib_sub <= r_nib_sub + 3'd1;
                            end
                        end
                    end
                    default: begin
                        r_state    <= c_HUNT;
                        r_zero_cnt <= 5'd0;
                    end
                endcase
            end
        end
    end

    // Output stage: strobes and held channel/user values
    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= 24'd0;
            r_out_chan   <= 3'd0;
            r_out_user   <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= r_emit_pend;
            r_frame_done <= r_done_pend;
            if (r_emit_pend) begin
                r_out_data <= r_sample_sr;
                r_out_chan <= r_emit_chan;
            end
            if (r_done_pend) begin
                r_out_user <= r_user_sr;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_chan   = r_out_chan;
    assign out_valid  = r_out_valid;
    assign out_user   = r_out_user;
    assign frame_done = r_frame_done;
    assign locked     = r_locked;
    assign sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_adat_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adat_frame_decoder
// Description : Directed self-checking bench for adat_frame_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adat_frame_decoder;

    logic        refclk = 1'b0;
    logic        reset;
    logic        sync_stream;
    logic        bclk;
    logic [23:0] out_data;
    logic [2:0]  out_chan;
    logic        out_valid;
    logic [3:0]  out_user;
    logic        frame_done;
    logic        locked;
    logic        sync_err;

    int n_checks = 0;
    int n_errors = 0;

    adat_frame_decoder #(
        .SYNC_ZEROS (10),
        .LOCK_FRAMES(2),
        .WDOG_CYCLES(64)
    ) dut (
        .refclk     (refclk),
        .reset      (reset),
        .sync_stream(sync_stream),
        .bclk       (bclk),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_user   (out_user),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 refclk = ~refclk;

    logic [2:0]  rx_chan[$];
    logic [23:0] rx_data[$];
    int          n_done = 0;
    int          n_serr = 0;

    always @(negedge refclk) begin
        if (out_valid) begin
            rx_chan.push_back(out_chan);
            rx_data.push_back(out_data);
        end
        if (frame_done) n_done++;
        if (sync_err)   n_serr++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic        fb[0:299];
    int          fb_len;
    logic [23:0] ch_data[8];
    logic        lvl = 1'b0;

    task automatic build_frame(input logic [3:0] u, input int zeros, input int fault_nib);
        int          k;
        logic [23:0] w;
        logic [3:0]  nib;
        k = 0;
        for (int i = 0; i < zeros; i++) begin fb[k] = 1'b0; k++; end
        fb[k] = 1'b1; k++;
        for (int i = 3; i >= 0; i--) begin fb[k] = u[i]; k++; end
        fb[k] = 1'b1; k++;
        for (int j = 0; j < 48; j++) begin
            w   = ch_data[j / 6];
            nib = w[23 - 4 * (j % 6) -: 4];
            for (int b = 3; b >= 0; b--) begin fb[k] = nib[b]; k++; end
            fb[k] = (j == fault_nib) ? 1'b0 : 1'b1; k++;
        end
        fb_len = k;
    endtask

    // One decoded bit: NRZI level set, then a bclk rising edge mid-bit
    task automatic send_bit(input logic b);
        if (b) lvl = ~lvl;
        sync_stream = lvl;
        bclk = 1'b0;
        repeat (4) @(negedge refclk);
        bclk = 1'b1;
        repeat (4) @(negedge refclk);
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to; i++) send_bit(fb[i]);
    endtask

    task automatic expect_frame(input string tag, input int n_exp);
        int n;
        check_val({tag, "_nvalid"}, rx_chan.size(), n_exp);
        n = (rx_chan.size() < n_exp) ? rx_chan.size() : n_exp;
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_chan%0d", tag, i), {29'd0, rx_chan[i]}, i);
            check_val($sformatf("%s_data%0d", tag, i), {8'd0, rx_data[i]}, {8'd0, ch_data[i]});
        end
        rx_chan.delete();
        rx_data.delete();
    endtask

    task automatic clean_frame(input string tag, input logic [3:0] u, input int zeros);
        build_frame(u, zeros, -1);
        send_range(0, fb_len);
        expect_frame(tag, 8);
        check_val({tag, "_user"}, {28'd0, out_user}, {28'd0, u});
    endtask

    int serr0;
    int done0;

    initial begin
        reset       = 1'b0;
        sync_stream = 1'b0;
        bclk        = 1'b0;
        for (int n = 0; n < 8; n++) ch_data[n] = 24'h100000 * n + 24'h000123;
        repeat (5) @(negedge refclk);
        check_val("rst_valid",  {31'd0, out_valid}, 0);
        check_val("rst_locked", {31'd0, locked}, 0);
        check_val("rst_data",   {8'd0, out_data}, 0);
        check_val("rst_user",   {28'd0, out_user}, 0);
        check_val("rst_serr",   {31'd0, sync_err}, 0);
        reset = 1'b1;
        @(negedge refclk);

        // Clean stream, lock after the second frame
        for (int f = 0; f < 3; f++) begin
            clean_frame($sformatf("clean%0d", f), 4'hA, 10);
            check_val($sformatf("clean%0d_done", f), n_done, f + 1);
            check_val($sformatf("clean%0d_locked", f), {31'd0, locked}, (f >= 1) ? 1 : 0);
        end
        check_val("clean_serr", n_serr, 0);

        // Separator fault on nibble 13 (channel 2)
        serr0 = n_serr;
        done0 = n_done;
        build_frame(4'hA, 10, 13);
        send_range(0, fb_len);
        expect_frame("sepf", 2);
        check_val("sepf_serr",   n_serr - serr0, 1);
        check_val("sepf_locked", {31'd0, locked}, 0);
        check_val("sepf_done",   n_done - done0, 0);
        clean_frame("relock0", 4'hA, 10);
        check_val("relock0_locked", {31'd0, locked}, 0);
        clean_frame("relock1", 4'hA, 10);
        check_val("relock1_locked", {31'd0, locked}, 1);

        // Short sync while locked
        serr0 = n_serr;
        for (int i = 0; i < 9; i++) send_bit(1'b0);
        send_bit(1'b1);
        check_val("short_serr",   n_serr - serr0, 1);
        check_val("short_locked", {31'd0, locked}, 0);
        check_val("short_nvalid", rx_chan.size(), 0);
        clean_frame("aftshort0", 4'hA, 10);
        clean_frame("aftshort1", 4'hA, 10);
        check_val("aftshort_locked", {31'd0, locked}, 1);

        // Long sync, new data and user bits
        for (int n = 0; n < 8; n++) ch_data[n] = 24'h800001 + 24'h010203 * n;
        serr0 = n_serr;
        clean_frame("long", 4'h5, 14);
        check_val("long_serr",   n_serr - serr0, 0);
        check_val("long_locked", {31'd0, locked}, 1);

        // Watchdog: bclk stopped well past the limit
        serr0 = n_serr;
        bclk = 1'b0;
        repeat (100) @(negedge refclk);
        check_val("wdog_serr",   n_serr - serr0, 1);
        check_val("wdog_locked", {31'd0, locked}, 0);
        clean_frame("wdre0", 4'h5, 10);
        check_val("wdre0_locked", {31'd0, locked}, 0);
        clean_frame("wdre1", 4'h5, 10);
        check_val("wdre1_locked", {31'd0, locked}, 1);

        // Reset at bit 120 of a valid frame
        build_frame(4'h5, 10, -1);
        send_range(0, 120);
        check_val("prerst_locked", {31'd0, locked}, 1);
        bclk = 1'b0;
        @(negedge refclk);
        reset = 1'b0;
        #1;
        check_val("mrst_locked", {31'd0, locked}, 0);
        check_val("mrst_user",   {28'd0, out_user}, 0);
        check_val("mrst_data",   {8'd0, out_data}, 0);
        check_val("mrst_chan",   {29'd0, out_chan}, 0);
        check_val("mrst_valid",  {31'd0, out_valid}, 0);
        @(negedge refclk);
        reset = 1'b1;
        rx_chan.delete();
        rx_data.delete();
        send_range(120, fb_len);
        check_val("mrst_nvalid", rx_chan.size(), 0);
        clean_frame("postrst", 4'h5, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
